// File: rtl/video_timing_engine.sv
// Raster timing generator: sync/DE counters, a centred display window, and an output stage
// that aligns video with frame-buffer data returned REQ_LAT cycles after each request.
module video_timing_engine #(
    parameter int unsigned IMAGE_WIDTH = 11,
    parameter int unsigned DATA_WIDTH  = 24,
    parameter int unsigned X_BITS      = 12,
    parameter int unsigned Y_BITS      = 12,
    parameter int unsigned H_SYNC      = 44,
    parameter int unsigned H_BACK      = 148,
    parameter int unsigned H_DISP      = 1920,
    parameter int unsigned H_FRONT     = 88,
    parameter int unsigned H_TOTAL     = 2200,
    parameter int unsigned V_SYNC      = 5,
    parameter int unsigned V_BACK      = 36,
    parameter int unsigned V_DISP      = 1080,
    parameter int unsigned V_FRONT     = 4,
    parameter int unsigned V_TOTAL     = 1125,
    parameter bit          HS_POL      = 1'b1,
    parameter bit          VS_POL      = 1'b1,
    parameter int unsigned REQ_LAT     = 2,
    parameter logic [DATA_WIDTH-1:0] BORDER_COLOR = '0
) (
    input  logic                   pix_clk,
    input  logic                   rst,
    input  logic                   en,
    input  logic [1:0]             mode,
    input  logic [IMAGE_WIDTH-1:0] disp_w,
    input  logic [IMAGE_WIDTH-1:0] disp_h,
    output logic                   pixel_req,
    output logic [IMAGE_WIDTH-1:0] pix_x,
    output logic [IMAGE_WIDTH-1:0] pix_y,
    input  logic [DATA_WIDTH-1:0]  pixel_data,
    output logic                   frame_end,
    output logic                   video_hs,
    output logic                   video_vs,
    output logic                   video_de,
    output logic [DATA_WIDTH-1:0]  video_data
);

    if (H_TOTAL != H_SYNC + H_BACK + H_DISP + H_FRONT) begin : g_bad_h_timing
        $error("H_TOTAL does not equal the sum of the horizontal intervals");
    end
    if (V_TOTAL != V_SYNC + V_BACK + V_DISP + V_FRONT) begin : g_bad_v_timing
        $error("V_TOTAL does not equal the sum of the vertical intervals");
    end
    if (REQ_LAT < 1 || REQ_LAT > 8) begin : g_bad_req_lat
        $error("REQ_LAT must be in 1..8");
    end

    localparam int unsigned Last = REQ_LAT - 1;

    localparam logic [X_BITS-1:0] HLast      = X_BITS'(H_TOTAL - 1);
    localparam logic [X_BITS-1:0] HSyncEnd   = X_BITS'(H_SYNC);
    localparam logic [X_BITS-1:0] HActStart  = X_BITS'(H_SYNC + H_BACK);
    localparam logic [X_BITS-1:0] HActEnd    = X_BITS'(H_SYNC + H_BACK + H_DISP);
    localparam logic [Y_BITS-1:0] VLast      = Y_BITS'(V_TOTAL - 1);
    localparam logic [Y_BITS-1:0] VSyncEnd   = Y_BITS'(V_SYNC);
    localparam logic [Y_BITS-1:0] VActStart  = Y_BITS'(V_SYNC + V_BACK);
    localparam logic [Y_BITS-1:0] VActEnd    = Y_BITS'(V_SYNC + V_BACK + V_DISP);
    localparam logic [IMAGE_WIDTH-1:0] HDispW = IMAGE_WIDTH'(H_DISP);
    localparam logic [IMAGE_WIDTH-1:0] VDispW = IMAGE_WIDTH'(V_DISP);

    typedef enum logic [0:0] {StIdle, StRun} state_e;

    state_e                 state_q, state_d;
    logic                   running;
    logic                   last_pos;
    logic                   frame_bnd;
    logic [X_BITS-1:0]      h_cnt_q;
    logic [Y_BITS-1:0]      v_cnt_q;
    logic [1:0]             mode_q;
    logic [IMAGE_WIDTH-1:0] win_w_q, win_h_q;

    assign last_pos  = (h_cnt_q == HLast) && (v_cnt_q == VLast);
    assign frame_bnd = (state_q == StIdle) || last_pos;

    always_ff @(posedge pix_clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (frame_bnd) begin
            state_d = en ? StRun : StIdle;
        end
    end

    always_comb begin
        running = (state_q == StRun);
    end

    always_ff @(posedge pix_clk or posedge rst) begin
        if (rst) begin
            h_cnt_q <= '0;
            v_cnt_q <= '0;
        end else if (!running) begin
            h_cnt_q <= '0;
            v_cnt_q <= '0;
        end else if (h_cnt_q == HLast) begin
            h_cnt_q <= '0;
            v_cnt_q <= (v_cnt_q == VLast) ? '0 : v_cnt_q + Y_BITS'(1);
        end else begin
            h_cnt_q <= h_cnt_q + X_BITS'(1);
        end
    end

    // Frame parameters only change between frames so a frame is never torn.
    always_ff @(posedge pix_clk or posedge rst) begin
        if (rst) begin
            mode_q  <= '0;
            win_w_q <= '0;
            win_h_q <= '0;
        end else if (frame_bnd) begin
            mode_q  <= mode;
            win_w_q <= (disp_w > HDispW) ? HDispW : disp_w;
            win_h_q <= (disp_h > VDispW) ? VDispW : disp_h;
        end
    end

    logic                   hs_act, vs_act, de_act, in_win;
    logic [X_BITS-1:0]      act_x, x_lo, x_hi;
    logic [Y_BITS-1:0]      act_y, y_lo, y_hi;
    logic [IMAGE_WIDTH-1:0] win_x, win_y;

    always_comb begin
        hs_act = running && (h_cnt_q < HSyncEnd);
        vs_act = running && (v_cnt_q < VSyncEnd);
        de_act = running && (h_cnt_q >= HActStart) && (h_cnt_q < HActEnd) &&
                 (v_cnt_q >= VActStart) && (v_cnt_q < VActEnd);
        act_x  = h_cnt_q - HActStart;
        act_y  = v_cnt_q - VActStart;
        x_lo   = X_BITS'((HDispW - win_w_q) >> 1);
        y_lo   = Y_BITS'((VDispW - win_h_q) >> 1);
        x_hi   = x_lo + X_BITS'(win_w_q);
        y_hi   = y_lo + Y_BITS'(win_h_q);
        in_win = de_act && (act_x >= x_lo) && (act_x < x_hi) &&
                 (act_y >= y_lo) && (act_y < y_hi);
        win_x  = IMAGE_WIDTH'(act_x - x_lo);
        win_y  = IMAGE_WIDTH'(act_y - y_lo);
    end

    assign pixel_req = in_win && (mode_q == 2'd0);
    assign pix_x     = pixel_req ? win_x : '0;
    assign pix_y     = pixel_req ? win_y : '0;
    assign frame_end = running && last_pos;

    logic [IMAGE_WIDTH-1:0] bar_w;
    logic [2:0]             bar_idx;
    logic [DATA_WIDTH-1:0]  bar_col, pat_col;

    // Bar index = number of bar boundaries already passed; a zero bar width saturates at 7.
    always_comb begin
        bar_w   = win_w_q >> 3;
        bar_idx = '0;
        for (int k = 1; k < 8; k++) begin
            if (win_x >= IMAGE_WIDTH'(k) * bar_w) begin
                bar_idx = 3'(k);
            end
        end
        case (bar_idx)
            3'd0:    bar_col = DATA_WIDTH'(24'hFFFFFF);
            3'd1:    bar_col = DATA_WIDTH'(24'hFFFF00);
            3'd2:    bar_col = DATA_WIDTH'(24'h00FFFF);
            3'd3:    bar_col = DATA_WIDTH'(24'h00FF00);
            3'd4:    bar_col = DATA_WIDTH'(24'hFF00FF);
            3'd5:    bar_col = DATA_WIDTH'(24'hFF0000);
            3'd6:    bar_col = DATA_WIDTH'(24'h0000FF);
            default: bar_col = DATA_WIDTH'(24'h000000);
        endcase
        case (mode_q)
            2'd1:    pat_col = bar_col;
            2'd3:    pat_col = ((win_x[4:0] == 5'd0) || (win_y[4:0] == 5'd0)) ?
                               DATA_WIDTH'(24'hFFFFFF) : '0;
            default: pat_col = BORDER_COLOR;
        endcase
        if (!in_win) begin
            pat_col = BORDER_COLOR;
        end
    end

    // Patterns ride the same delay line as the flags so every mode has identical latency.
    logic [REQ_LAT-1:0]    hs_pipe_q, vs_pipe_q, de_pipe_q, ext_pipe_q;
    logic [DATA_WIDTH-1:0] col_pipe_q [REQ_LAT];
    logic                  video_hs_q, video_vs_q, video_de_q;
    logic [DATA_WIDTH-1:0] video_data_q;

    always_ff @(posedge pix_clk or posedge rst) begin
        if (rst) begin
            hs_pipe_q    <= '0;
            vs_pipe_q    <= '0;
            de_pipe_q    <= '0;
            ext_pipe_q   <= '0;
            for (int i = 0; i < REQ_LAT; i++) begin
                col_pipe_q[i] <= '0;
            end
            video_hs_q   <= ~HS_POL;
            video_vs_q   <= ~VS_POL;
            video_de_q   <= 1'b0;
            video_data_q <= '0;
        end else begin
            hs_pipe_q[0]  <= hs_act;
            vs_pipe_q[0]  <= vs_act;
            de_pipe_q[0]  <= de_act;
            ext_pipe_q[0] <= pixel_req;
            col_pipe_q[0] <= pat_col;
            for (int i = 1; i < REQ_LAT; i++) begin
                hs_pipe_q[i]  <= hs_pipe_q[i-1];
                vs_pipe_q[i]  <= vs_pipe_q[i-1];
                de_pipe_q[i]  <= de_pipe_q[i-1];
                ext_pipe_q[i] <= ext_pipe_q[i-1];
                col_pipe_q[i] <= col_pipe_q[i-1];
            end
            video_hs_q   <= hs_pipe_q[Last] ? HS_POL : ~HS_POL;
            video_vs_q   <= vs_pipe_q[Last] ? VS_POL : ~VS_POL;
            video_de_q   <= de_pipe_q[Last];
            video_data_q <= !de_pipe_q[Last] ? '0 :
                            ext_pipe_q[Last] ? pixel_data : col_pipe_q[Last];
        end
    end

    assign video_hs   = video_hs_q;
    assign video_vs   = video_vs_q;
    assign video_de   = video_de_q;
    assign video_data = video_data_q;

endmodule

// File: tb/tb_video_timing_engine.sv
// Bench for video_timing_engine on a small raster: frame-position model checked every cycle,
// plus hand-computed per-frame counts and captured pixels.
module tb_video_timing_engine;

    localparam int HS = 4, HB = 4, HD = 16, HF = 4, HT = 28;
    localparam int VS = 2, VB = 2, VD = 8, VF = 2, VT = 14;
    localparam int LAT = 2;
    localparam int FRAME = HT * VT;
    localparam logic [23:0] BORDER = 24'h204060;

    logic        pix_clk = 1'b0;
    logic        rst = 1'b1;
    logic        en = 1'b0;
    logic [1:0]  mode = 2'd2;
    logic [10:0] disp_w = 11'd16;
    logic [10:0] disp_h = 11'd8;
    logic        pixel_req;
    logic [10:0] pix_x, pix_y;
    logic [23:0] pixel_data;
    logic        frame_end, video_hs, video_vs, video_de;
    logic [23:0] video_data;

    video_timing_engine #(
        .IMAGE_WIDTH(11), .DATA_WIDTH(24), .X_BITS(12), .Y_BITS(12),
        .H_SYNC(HS), .H_BACK(HB), .H_DISP(HD), .H_FRONT(HF), .H_TOTAL(HT),
        .V_SYNC(VS), .V_BACK(VB), .V_DISP(VD), .V_FRONT(VF), .V_TOTAL(VT),
        .HS_POL(1'b1), .VS_POL(1'b1), .REQ_LAT(LAT), .BORDER_COLOR(BORDER)
    ) dut (
        .pix_clk(pix_clk), .rst(rst), .en(en), .mode(mode),
        .disp_w(disp_w), .disp_h(disp_h),
        .pixel_req(pixel_req), .pix_x(pix_x), .pix_y(pix_y), .pixel_data(pixel_data),
        .frame_end(frame_end), .video_hs(video_hs), .video_vs(video_vs),
        .video_de(video_de), .video_data(video_data)
    );

    always #5 pix_clk = ~pix_clk;

    // Frame-buffer stand-in: returns {x,y} exactly two cycles after a request.
    logic [23:0] mem1 = '0, mem2 = '0;
    always @(posedge pix_clk) begin
        mem1 <= pixel_req ? {2'b00, pix_x, pix_y} : 24'h0;
        mem2 <= mem1;
    end
    assign pixel_data = mem2;

    // Model state: frame position as a single linear index plus the per-frame settings.
    typedef struct {
        bit run;
        int pos;
        int md;
        int w;
        int h;
    } st_t;

    st_t hist [4];  // hist[0] = this cycle, hist[k] = k cycles ago

    function automatic st_t step(st_t c);
        st_t n = c;
        n.pos = c.run ? ((c.pos == FRAME - 1) ? 0 : c.pos + 1) : 0;
        if (!c.run || c.pos == FRAME - 1) begin
            n.run = en;
            n.md  = int'(mode);
            n.w   = (int'(disp_w) > HD) ? HD : int'(disp_w);
            n.h   = (int'(disp_h) > VD) ? VD : int'(disp_h);
        end
        return n;
    endfunction

    always @(posedge pix_clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 4; i++) hist[i] <= '{default: 0};
        end else begin
            hist[0] <= step(hist[0]);
            for (int i = 1; i < 4; i++) hist[i] <= hist[i-1];
        end
    end

    function automatic void decode(input st_t s, output bit act, output bit inw,
                                   output int x, output int y);
        int ax, ay, x0, y0;
        ax  = (s.pos % HT) - (HS + HB);
        ay  = (s.pos / HT) - (VS + VB);
        act = s.run && ax >= 0 && ax < HD && ay >= 0 && ay < VD;
        x0  = (HD - s.w) / 2;
        y0  = (VD - s.h) / 2;
        inw = act && ax >= x0 && ax < x0 + s.w && ay >= y0 && ay < y0 + s.h;
        x   = ax - x0;
        y   = ay - y0;
    endfunction

    function automatic logic [23:0] bar_colour(int idx);
        case (idx)
            0: return 24'hFFFFFF;
            1: return 24'hFFFF00;
            2: return 24'h00FFFF;
            3: return 24'h00FF00;
            4: return 24'hFF00FF;
            5: return 24'hFF0000;
            6: return 24'h0000FF;
            default: return 24'h000000;
        endcase
    endfunction

    function automatic logic [23:0] pattern(int md, int w, int x, int y);
        int bw, idx;
        case (md)
            0: return 24'(x * 2048 + y);
            1: begin
                bw  = w / 8;
                idx = (bw == 0) ? 7 : x / bw;
                if (idx > 7) idx = 7;
                return bar_colour(idx);
            end
            3: return ((x % 32 == 0) || (y % 32 == 0)) ? 24'hFFFFFF : 24'h000000;
            default: return BORDER;
        endcase
    endfunction

    int checks = 0;
    int errors = 0;

    task automatic check(string name, logic [63:0] actual, logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, actual, expected, $time);
        end
    endtask

    task automatic compare_cycle();
        bit act, inw, rq, fe, hs, vs;
        int x, y;
        logic [23:0] data;
        decode(hist[0], act, inw, x, y);
        rq = inw && hist[0].md == 0;
        fe = hist[0].run && hist[0].pos == FRAME - 1;
        check("counter_side", {pixel_req, pix_x, pix_y, frame_end},
              {rq, rq ? 11'(x) : 11'd0, rq ? 11'(y) : 11'd0, fe});
        decode(hist[LAT+1], act, inw, x, y);
        hs   = hist[LAT+1].run && (hist[LAT+1].pos % HT) < HS;
        vs   = hist[LAT+1].run && (hist[LAT+1].pos / HT) < VS;
        data = !act ? 24'h0 : !inw ? BORDER : pattern(hist[LAT+1].md, hist[LAT+1].w, x, y);
        check("video_side", {video_hs, video_vs, video_de, video_data}, {hs, vs, act, data});
    endtask

    // Per-frame monitor, snapshotted on each frame_end pulse.
    int cyc = 0, last_fe = 0, fe_interval = 0, fe_count = 0;
    int live_req = 0, live_de = 0, live_hs = 0, live_vs = 0;
    int fr_req = 0, fr_de = 0, fr_hs = 0, fr_vs = 0;
    bit first_seen = 0;
    int live_fx = 0, live_fy = 0, fr_fx = -1, fr_fy = -1;
    int row = 0, col = 0;
    bit prev_de = 0;
    logic [23:0] cap [8][16];

    task automatic tick();
        @(negedge pix_clk);
        cyc++;
        compare_cycle();
        if (pixel_req) begin
            live_req++;
            if (!first_seen) begin
                first_seen = 1;
                live_fx = int'(pix_x);
                live_fy = int'(pix_y);
            end
        end
        if (video_de) live_de++;
        if (video_hs) live_hs++;
        if (video_vs) live_vs++;
        if (video_de) begin
            if (!prev_de) col = 0;
            if (row < 8 && col < 16) cap[row][col] = video_data;
            col++;
        end else if (prev_de) begin
            row++;
        end
        prev_de = video_de;
        if (frame_end) begin
            fr_req = live_req; fr_de = live_de; fr_hs = live_hs; fr_vs = live_vs;
            fr_fx = first_seen ? live_fx : -1;
            fr_fy = first_seen ? live_fy : -1;
            live_req = 0; live_de = 0; live_hs = 0; live_vs = 0; first_seen = 0;
            row = 0;
            fe_interval = cyc - last_fe;
            last_fe = cyc;
            fe_count++;
        end
    endtask

    task automatic wait_fe(string name);
        int n = 0;
        do begin
            tick();
            n++;
        end while (!frame_end && n < 2 * FRAME);
        check(name, frame_end, 1'b1);
    endtask

    task automatic start_latency(string name);
        int n = 0;
        do begin
            tick();
            n++;
        end while (video_hs !== 1'b1 && n < 20);
        check(name, n, 4);
    endtask

    initial begin
        int fe_before;

        // Reset state and start-up from reset
        repeat (3) tick();
        check("reset_idle", {video_hs, video_vs, video_de, video_data, pixel_req, frame_end},
              '0);
        rst = 1'b0;
        en  = 1'b1;
        start_latency("start_after_reset");

        // Full-window timing in mode 2
        wait_fe("t2_fe_a");
        wait_fe("t2_fe_b");
        check("t2_de_per_frame", fr_de, 128);
        check("t2_hs_per_frame", fr_hs, 14 * 4);
        check("t2_vs_per_frame", fr_vs, 2 * HT);
        check("t2_frame_period", fe_interval, 392);
        check("t2_no_req", fr_req, 0);
        check("t2_border", cap[0][0], BORDER);

        // Asynchronous reset mid-frame
        repeat (100) tick();
        rst = 1'b1;
        #1;
        check("midframe_reset_idle",
              {video_hs, video_vs, video_de, video_data, pixel_req, frame_end}, '0);
        repeat (3) tick();
        rst = 1'b0;
        start_latency("restart_after_reset");

        // External source, 8x4 window centred at cols 4..11, rows 2..5
        mode = 2'd0; disp_w = 11'd8; disp_h = 11'd4;
        wait_fe("t3_fe_a");
        wait_fe("t3_fe_b");
        check("t3_req_count", fr_req, 32);
        check("t3_first_req", {fr_fx[15:0], fr_fy[15:0]}, 32'h0000_0000);
        check("t3_first_pix", cap[2][4], 24'h000000);
        check("t3_last_pix", cap[5][11], 24'h003803);
        check("t3_border_tl", cap[0][0], BORDER);
        check("t3_border_left", cap[2][3], BORDER);
        check("t3_border_right", cap[2][12], BORDER);

        // Width clamp and empty window
        disp_w = 11'd40; disp_h = 11'd8;
        wait_fe("t4_fe_a");
        wait_fe("t4_fe_b");
        check("t4_clamp_req", fr_req, 128);
        check("t4_clamp_first", cap[0][0], 24'h000000);
        check("t4_clamp_last", cap[7][15], 24'h007807);
        disp_w = 11'd0;
        wait_fe("t4_fe_c");
        wait_fe("t4_fe_d");
        check("t4_empty_req", fr_req, 0);
        check("t4_empty_de", fr_de, 128);
        check("t4_empty_border", cap[3][7], BORDER);

        // Colour bars and grid
        mode = 2'd1; disp_w = 11'd16; disp_h = 11'd8;
        wait_fe("t5_fe_a");
        wait_fe("t5_fe_b");
        check("t5_bar0", cap[3][0], 24'hFFFFFF);
        check("t5_bar1", cap[3][2], 24'hFFFF00);
        check("t5_bar6", cap[3][13], 24'h0000FF);
        check("t5_bar7", cap[3][14], 24'h000000);
        mode = 2'd3;
        wait_fe("t5_fe_c");
        wait_fe("t5_fe_d");
        check("t5_grid_row0", cap[0][5], 24'hFFFFFF);
        check("t5_grid_col0", cap[3][0], 24'hFFFFFF);
        check("t5_grid_inner", cap[3][5], 24'h000000);

        // Mode change and disable mid-frame: frame finishes as grid, then idle
        wait_fe("t6_fe_a");
        repeat (50) tick();
        mode = 2'd1;
        en   = 1'b0;
        wait_fe("t6_fe_b");
        check("t6_frame_unchanged", cap[3][5], 24'h000000);
        check("t6_frame_de", fr_de, 128);
        fe_before = fe_count;
        repeat (FRAME + 20) tick();
        check("t6_idle_no_fe", fe_count - fe_before, 0);
        check("t6_idle_outputs", {video_hs, video_vs, video_de, pixel_req}, 4'b0000);
        en = 1'b1;
        start_latency("t6_restart");
        wait_fe("t6_fe_c");
        check("t6_new_mode", cap[3][5], 24'h00FFFF);
        check("t6_new_de", fr_de, 128);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
